// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the sequential multiplier and its display path:
//   - state_t   : multiplier FSM encoding (IDLE, RUN, DONE)
//   - SEG_*     : active-low seven-segment codes, bit order {dp,g,f,e,d,c,b,a}
//   - hex_digit_count() : number of hex digits needed for a product of a given width
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Hex glyphs. 'b' and 'd' also light the decimal point so they can be
    // told apart from '8' and '0' on the display.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h00;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'h40;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // ceil(bits/4)
    function automatic int hex_digit_count(input int bits);
        return (bits + 3) / 4;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg
// Combinational hex nibble to active-low seven-segment decoder.
//   nibble : in  4  hex value to show
//   seg    : out 8  active-low segments {dp,g,f,e,d,c,b,a}
module hex_to_seg
    import mult_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seq_multiplier_display.sv
// seq_multiplier_display
// Shift-add unsigned multiplier (one multiplier bit per clock) with a
// start/done handshake, plus a time-multiplexed common-anode hex display of
// the last completed product.
//   i_clk    : in  1          system clock
//   i_rst_n  : in  1          asynchronous active-low reset
//   i_start  : in  1          start request, only honoured while the FSM is idle
//   i_A      : in  WIDTH      multiplicand (unsigned)
//   i_B      : in  WIDTH      multiplier (unsigned)
//   o_busy   : out 1          multiply in progress (start edge through done cycle)
//   o_done   : out 1          one-cycle pulse when o_R takes a new product
//   o_R      : out 2*WIDTH    last completed product
//   o_seg    : out 8          active-low segments of the lit digit
//   o_an     : out R_DIGITS   active-low digit enables, one low at a time
module seq_multiplier_display
    import mult_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int SCAN_DIV = 50000,
    localparam int R_DIGITS = (2 * WIDTH + 3) / 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_A,
    input  logic [WIDTH-1:0]      i_B,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2*WIDTH-1:0]    o_R,
    output logic [7:0]            o_seg,
    output logic [R_DIGITS-1:0]   o_an
);

    localparam int PW     = 2 * WIDTH;
    localparam int PAD_W  = 4 * hex_digit_count(PW);
    localparam int CNT_W  = $clog2(WIDTH);
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = (R_DIGITS > 1) ? $clog2(R_DIGITS) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(R_DIGITS - 1);

    // ------------------------------------------------------------------
    // Multiplier FSM and datapath
    // ------------------------------------------------------------------
    state_t             state;
    logic [PW-1:0]      mcand;
    logic [WIDTH-1:0]   mplier;
    logic [PW-1:0]      acc;
    logic [CNT_W-1:0]   bit_cnt;

    // o_busy is held through the DONE cycle and drops on the following edge,
    // which is also the first edge at which IDLE can accept a new start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            bit_cnt <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_R     <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_busy <= 1'b0;
                    if (i_start) begin
                        mcand   <= PW'(i_A);
                        mplier  <= i_B;
                        acc     <= '0;
                        bit_cnt <= '0;
                        o_busy  <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_R    <= acc;
                    o_done <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scan: free-running divider selects which digit is lit
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  digit_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
        end
    end

    // Product zero-extended to a whole number of nibbles so the top digit
    // reads cleanly when 2*WIDTH is not a multiple of 4.
    logic [PAD_W-1:0] product_pad;
    logic [PAD_W-1:0] product_shift;
    logic [3:0]       nibble;
    logic [7:0]       seg_code;

    always_comb begin
        product_pad   = PAD_W'(o_R);
        product_shift = product_pad >> {digit_idx, 2'b00};
        nibble        = product_shift[3:0];
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (seg_code)
    );

    // Segment and anode outputs are registered together so the two always
    // switch on the same edge and never glitch to two lit digits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_seg <= SEG_0;
            o_an  <= ~R_DIGITS'(1);
        end else begin
            o_seg <= seg_code;
            o_an  <= ~(R_DIGITS'(1) << digit_idx);
        end
    end

endmodule

// File: tb/tb_seq_multiplier_display.sv
module tb_seq_multiplier_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // index 0: WIDTH=4, SCAN_DIV=4 ; index 1: WIDTH=6, SCAN_DIV=3
    int wid[2]  = '{4, 6};
    int sdiv[2] = '{4, 3};
    int ndig[2] = '{2, 3};

    logic        start_v[2];
    logic [15:0] a_v[2];
    logic [15:0] b_v[2];

    logic        busy4, done4, busy6, done6;
    logic [7:0]  r4;
    logic [11:0] r6;
    logic [7:0]  seg4, seg6;
    logic [1:0]  an4;
    logic [2:0]  an6;

    seq_multiplier_display #(.WIDTH(4), .SCAN_DIV(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[0]),
        .i_A(a_v[0][3:0]), .i_B(b_v[0][3:0]),
        .o_busy(busy4), .o_done(done4), .o_R(r4), .o_seg(seg4), .o_an(an4)
    );

    seq_multiplier_display #(.WIDTH(6), .SCAN_DIV(3)) dut6 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_v[1]),
        .i_A(a_v[1][5:0]), .i_B(b_v[1][5:0]),
        .o_busy(busy6), .o_done(done6), .o_R(r6), .o_seg(seg6), .o_an(an6)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] seg_tab[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h00, 8'hC6, 8'h40, 8'h86, 8'h8E};

    // Reference model, in terms of edge numbers since reset release:
    // a start accepted at edge n is busy for edges n..n+W+1, publishes the
    // product at edge n+W+1, and the next start can be taken at edge n+W+2.
    int          e;
    int          ready[2];
    int          done_at[2];
    logic [31:0] pend[2];
    logic [31:0] mr[2];
    logic [31:0] mr_prev[2];
    int          dcnt[2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e = 0;
            for (int i = 0; i < 2; i++) begin
                ready[i]   = 0;
                done_at[i] = -1;
                pend[i]    = 0;
                mr[i]      = 0;
                mr_prev[i] = 0;
            end
        end else begin
            e++;
            for (int i = 0; i < 2; i++) begin
                logic [31:0] mask;
                mask = (32'd1 << wid[i]) - 1;
                mr_prev[i] = mr[i];
                if (e == done_at[i]) mr[i] = pend[i];
                if (start_v[i] && e >= ready[i]) begin
                    pend[i]    = (32'(a_v[i]) & mask) * (32'(b_v[i]) & mask);
                    done_at[i] = e + wid[i] + 1;
                    ready[i]   = e + wid[i] + 2;
                end
            end
        end
    end

    // Lit digit after edge e reflects the digit index and product as they
    // stood after edge e-1 (outputs are registered).
    function automatic int exp_digit(input int i);
        return (e == 0) ? 0 : ((e - 1) / sdiv[i]) % ndig[i];
    endfunction

    function automatic logic [7:0] exp_seg(input int i);
        int d;
        d = exp_digit(i);
        return seg_tab[(mr_prev[i] >> (4 * d)) & 32'hF];
    endfunction

    function automatic logic [31:0] exp_an(input int i);
        return ~(32'd1 << exp_digit(i)) & ((32'd1 << ndig[i]) - 1);
    endfunction

    always @(negedge clk) begin
        check_val("busy4", busy4, e < ready[0]);
        check_val("done4", done4, e == done_at[0]);
        check_val("r4",    r4,    mr[0]);
        check_val("seg4",  seg4,  exp_seg(0));
        check_val("an4",   an4,   exp_an(0));
        check_val("busy6", busy6, e < ready[1]);
        check_val("done6", done6, e == done_at[1]);
        check_val("r6",    r6,    mr[1]);
        check_val("seg6",  seg6,  exp_seg(1));
        check_val("an6",   an6,   exp_an(1));
        if (done4) dcnt[0]++;
        if (done6) dcnt[1]++;
    end

    task automatic pulse(input int i, input int a, input int b);
        @(negedge clk);
        start_v[i] = 1'b1;
        a_v[i]     = 16'(a);
        b_v[i]     = 16'(b);
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    function automatic logic [15:0] pick(input int i);
        logic [15:0] m;
        m = 16'((32'd1 << wid[i]) - 1);
        case ($urandom % 4)
            0:       return 16'd0;
            1:       return m;
            default: return 16'($urandom) & m;
        endcase
    endfunction

    initial begin
        int d0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = '0;
            b_v[i]     = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_r4",   r4,    0);
        check_val("rst_busy", busy4, 0);
        check_val("rst_an4",  an4,   2'b10);
        check_val("rst_seg4", seg4,  8'hC0);

        // 15*15, operands disturbed right after capture
        d0 = dcnt[0];
        pulse(0, 15, 15);
        a_v[0] = 0;
        b_v[0] = 0;
        repeat (8) @(negedge clk);
        check_val("t1_r", r4, 8'hE1);
        check_val("t1_ndone", dcnt[0] - d0, 1);

        // back-to-back at the earliest accepted edge
        d0 = dcnt[0];
        pulse(0, 0, 9);
        repeat (4) @(negedge clk);
        pulse(0, 7, 1);
        check_val("b2b_r0", r4, 0);
        repeat (8) @(negedge clk);
        check_val("b2b_r1", r4, 7);
        check_val("b2b_ndone", dcnt[0] - d0, 2);

        // start during RUN is ignored
        d0 = dcnt[0];
        pulse(0, 3, 5);
        @(negedge clk);
        pulse(0, 9, 9);
        repeat (8) @(negedge clk);
        check_val("ign_r", r4, 15);
        check_val("ign_ndone", dcnt[0] - d0, 1);

        // reset mid-multiply
        pulse(0, 7, 7);
        repeat (8) @(negedge clk);
        d0 = dcnt[0];
        pulse(0, 12, 11);
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_mid_r", r4, 0);
        check_val("rst_mid_busy", busy4, 0);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_val("rst_mid_ndone", dcnt[0] - d0, 0);
        pulse(0, 12, 11);
        repeat (8) @(negedge clk);
        check_val("restart_r", r4, 8'h84);

        // WIDTH=6 full-scale product; scan is watched by the monitor
        pulse(1, 63, 63);
        repeat (10) @(negedge clk);
        check_val("w6_r", r6, 12'hF81);
        repeat (24) @(negedge clk);

        // random traffic, including starts while busy and operand churn
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                start_v[i] = (($urandom % 3) == 0);
                a_v[i]     = pick(i);
                b_v[i]     = pick(i);
            end
        end
        for (int i = 0; i < 2; i++) start_v[i] = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
